// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//
// Purpose: computes WIDTH*WORDS-bit A+B or A-B by running one shared
// WIDTH-bit combinational adder once per word, least-significant word
// first. The block owns the carry chain, the B inversion for subtract, the
// assembly of the result words and the signed-overflow flag. Operands arrive
// over a valid/ready request port, and the result leaves over a valid/ready
// result port.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/ready   operand request handshake (ready only while idle)
//   op_a, op_b, sub  N-bit operands; sub=1 selects A-B
//   out_valid/ready  result handshake (result held until accepted)
//   result           A +/- B modulo 2^N
//   cout             carry out of bit N-1 (for subtract 1 = no borrow)
//   overflow         two's-complement overflow of the N-bit operation
//   add_a/b/cin      drive the shared adder, zero whenever not iterating
//   add_sum/cout     shared adder outputs, combinational within one cycle
module wide_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] op_a,
  input  logic [WIDTH*WORDS-1:0] op_b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] result,
  output logic                   cout,
  output logic                   overflow,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state;
  logic [WORDS-1:0][WIDTH-1:0]   a_reg;
  logic [WORDS-1:0][WIDTH-1:0]   b_reg;
  logic [WORDS-1:0][WIDTH-1:0]   res_reg;
  logic                          carry;
  logic [IDXW-1:0]               idx;
  logic                          last_word;
  logic                          a_msb;
  logic                          beff_msb;

  assign last_word = (idx == LAST_IDX);
  assign a_msb     = a_reg[WORDS-1][WIDTH-1];
  assign beff_msb  = b_reg[WORDS-1][WIDTH-1];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_reg;

  // The adder sees operands only while iterating so it stays quiet otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[idx];
      add_b   = b_reg[idx];
      add_cin = carry;
    end
  end

  // B is stored already inverted for subtract and the chain starts with
  // carry=1, so the same adder pass computes A + ~B + 1 = A - B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= op_a;
            b_reg   <= sub ? ~op_b : op_b;
            carry   <= sub;
            idx     <= '0;
            res_reg <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          res_reg[idx] <= add_sum;
          carry        <= add_cout;
          if (last_word) begin
            // Signed overflow: operands of equal sign giving a sum of the
            // other sign. The top sum bit is the result MSB on this word.
            cout     <= add_cout;
            overflow <= (a_msb == beff_msb) && (add_sum[WIDTH-1] != a_msb);
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer
//
// Purpose: self-checking bench for wide_add_sequencer with WIDTH=32,
// WORDS=4. Provides the shared combinational adder, drives directed and
// random operations, and compares against an arithmetic reference model.
module tb_wide_add_sequencer;

  localparam int WIDTH = 32;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic             cout;
  logic             overflow;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  int total = 0;
  int bad   = 0;

  wide_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // Shared ripple adder seen by the sequencer.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAdderQuiet(input string tag);
    checkOutput({tag, "_add_a"}, N'(add_a), '0);
    checkOutput({tag, "_add_b"}, N'(add_b), '0);
    checkOutput({tag, "_add_cin"}, N'(add_cin), '0);
  endtask

  // Reference: plain N+1-bit unsigned and signed arithmetic.
  task automatic refModel(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          output logic [N-1:0] r, output logic c, output logic ov);
    logic [N:0] u;
    logic [N:0] sa;
    logic [N:0] sb;
    logic [N:0] sr;
    sa = {a[N-1], a};
    sb = {b[N-1], b};
    if (s) begin
      u  = {1'b0, a} - {1'b0, b};
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b};
      c  = u[N];
      sr = sa + sb;
    end
    r  = u[N-1:0];
    ov = sr[N] ^ sr[N-1];
  endtask

  // Carry entering word w of the operation: for add, whether the lower
  // bits overflow; for subtract, whether the lower bits need no borrow.
  function automatic logic carryInto(input logic [N-1:0] a, input logic [N-1:0] b,
                                     input logic s, input int w);
    logic [N:0] mask;
    logic [N:0] la;
    logic [N:0] lb;
    mask = ({{N{1'b0}}, 1'b1} << (WIDTH * w)) - 1'b1;
    la   = {1'b0, a} & mask;
    lb   = {1'b0, b} & mask;
    if (s) return (la >= lb);
    return ((la + lb) >> (WIDTH * w)) != '0;
  endfunction

  function automatic logic [N-1:0] randOperand();
    logic [N-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      2: v = {1'b0, {(N-1){1'b1}}};
      3: v = {1'b1, {(N-1){1'b0}}};
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  // One complete operation: accept, per-word adder checks, result checks,
  // a number of backpressure cycles, then the result handshake.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic s, input int hold);
    logic [N-1:0] expR;
    logic         expC;
    logic         expOv;
    logic [N-1:0] beff;
    refModel(a, b, s, expR, expC, expOv);
    beff = s ? ~b : b;
    @(negedge clk);
    checkOutput("accept_in_ready", N'(in_ready), N'(1));
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    sub      = s;
    @(posedge clk);
    for (int w = 0; w < WORDS; w++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      op_a      = randOperand();
      op_b      = randOperand();
      sub       = ~s;
      checkOutput("run_out_valid", N'(out_valid), '0);
      checkOutput("run_in_ready", N'(in_ready), '0);
      checkOutput("run_add_a", N'(add_a), N'(WIDTH'(a >> (WIDTH * w))));
      checkOutput("run_add_b", N'(add_b), N'(WIDTH'(beff >> (WIDTH * w))));
      checkOutput("run_add_cin", N'(add_cin), N'(carryInto(a, b, s, w)));
    end
    @(negedge clk);
    checkOutput("done_out_valid", N'(out_valid), N'(1));
    checkOutput("done_result", result, expR);
    checkOutput("done_cout", N'(cout), N'(expC));
    checkOutput("done_overflow", N'(overflow), N'(expOv));
    checkAdderQuiet("done");
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      op_a      = randOperand();
      @(negedge clk);
      checkOutput("hold_out_valid", N'(out_valid), N'(1));
      checkOutput("hold_in_ready", N'(in_ready), '0);
      checkOutput("hold_result", result, expR);
      checkOutput("hold_cout", N'(cout), N'(expC));
      checkOutput("hold_overflow", N'(overflow), N'(expOv));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'($urandom_range(0, 1));
    checkOutput("idle_in_ready", N'(in_ready), N'(1));
    checkOutput("idle_out_valid", N'(out_valid), '0);
    checkAdderQuiet("idle");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    #12;
    checkOutput("reset_in_ready", N'(in_ready), N'(1));
    checkOutput("reset_out_valid", N'(out_valid), '0);
    checkOutput("reset_result", result, '0);
    checkOutput("reset_cout", N'(cout), '0);
    checkOutput("reset_overflow", N'(overflow), '0);
    checkAdderQuiet("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed add/sub cases");
    applyStimulus(N'(128'hFFFF_FFFF), N'(1), 1'b0, 0);
    checkOutput("carry_word1_result", result, {{(N-33){1'b0}}, 1'b1, 32'h0});
    applyStimulus('1, N'(1), 1'b0, 0);
    applyStimulus({1'b0, {(N-1){1'b1}}}, N'(1), 1'b0, 0);
    applyStimulus(N'(5), N'(3), 1'b1, 0);
    applyStimulus(N'(3), N'(5), 1'b1, 0);
    applyStimulus({1'b1, {(N-1){1'b0}}}, N'(1), 1'b1, 0);

    $display("[TB] backpressure case");
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 3);
    applyStimulus(N'(100), N'(58), 1'b1, 0);

    $display("[TB] reset during iteration");
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = '1;
    op_b     = '1;
    sub      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", N'(out_valid), '0);
    checkOutput("midrst_in_ready", N'(in_ready), N'(1));
    checkOutput("midrst_result", result, '0);
    checkAdderQuiet("midrst");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(N'(7), N'(10), 1'b0, 0);
    checkOutput("fresh_result", result, N'(17));

    $display("[TB] random operations");
    for (int i = 0; i < 500; i++) begin
      applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
